instr_register_pipe: RTL
========================

Name: instr_register_pipe

Overview:
Parametrised, pipelined successor to the single-cycle instruction register. Each accepted instruction (opcode plus two signed operands) is executed in a registered ALU stage. The result is written into a DEPTH-entry register file and also emitted on a valid/ready result stream with backpressure. A registered read port returns stored instruction words together with a per-entry valid bit.

Parameters:
OP_WIDTH, 32, signed operand width in bits; result width is 2*OP_WIDTH
DEPTH, 32, number of register-file entries; must be a power of 2, ≥2
AW, $clog2(DEPTH), address width (localparam, not overridable)
IW_WIDTH, 4*OP_WIDTH+4, stored word width (localparam)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high reset
load_en  in  1  instruction valid
load_ready  out  1  pipeline can accept an instruction this cycle
opcode  in  3  ZERO=0 PASSA=1 PASSB=2 ADD=3 SUB=4 MULT=5 DIV=6 MOD=7
operand_a  in  OP_WIDTH  signed operand A
operand_b  in  OP_WIDTH  signed operand B
write_pointer  in  AW  destination entry
res_valid  out  1  result stream valid
res_ready  in  1  result stream consumer ready
res_data  out  2*OP_WIDTH  signed result
res_err  out  1  result error flag (divide/mod by zero)
res_ptr  out  AW  entry the result was written to
rd_en  in  1  read request
read_pointer  in  AW  read address
rd_valid  out  1  rd_data valid, 1 cycle after rd_en
rd_data  out  IW_WIDTH  {err, opcode, operand_a, operand_b, result}, MSB first
rd_hit  out  1  entry at read_pointer has been written since reset
instr_count  out  16  number of register-file writes since reset, saturating at 16'hFFFF

Behaviour:
- Reset (async, active-high): all outputs 0; all entries and valid bits 0; S1/S2 pipeline empty; instr_count 0. Asserting reset mid-operation drops in-flight instructions with no writes.
- Pipeline: S1 holds captured inputs (s1_valid); S2 holds the computed result (s2_valid).
  - s2_adv = !s2_valid || res_ready
  - s1_adv = !s1_valid || s2_adv
  - load_ready = s1_adv (combinational)
- Accept: load_en && load_ready at edge N captures inputs into S1.
- S1→S2 transfer (s1_valid && s2_adv) at edge N+1:
  - Computes the result, writes the entry {err, opcode, a, b, result} to write_pointer, sets its valid bit, and increments instr_count.
  - res_valid rises after edge N+1.
  - Minimum latency: accept to res_valid = 2 edges. Throughput is 1 per cycle when res_ready is held high.
- Result stream rules:
  - res_* hold stable while res_valid && !res_ready.
  - Transfer occurs on res_valid && res_ready.
  - Backpressure fills S2 and then S1, after which load_ready=0.
- Arithmetic: operands are sign-extended to 2*OP_WIDTH before the operation.
  - PASSA/PASSB: sign-extended operand.
  - ADD/SUB/MULT: full-width signed; no overflow is possible.
  - DIV: truncates toward zero. MOD: remainder takes the sign of operand_a.
  - DIV/MOD with operand_b==0: result 0, err=1.
  - ZERO and unused encodings: result 0, err=0.
- Read port:
  - rd_en at edge M gives rd_data = entry[read_pointer] and rd_hit = valid bit, with rd_valid=1 after edge M.
  - rd_valid is 0 in cycles following rd_en=0; rd_data holds its last value.
- Read/write collision: a read and a write to the same entry at the same edge returns the OLD contents and OLD valid bit (no bypass).
- Rewriting an occupied entry overwrites it silently; instr_count still increments.
- write_pointer and read_pointer wrap naturally at DEPTH.

Test Plan:
- Reset, then rd_en for every entry → rd_valid=1, rd_data=0, rd_hit=0; instr_count=0; load_ready=1.
- With res_ready=1, load {ADD, a=5, b=-7, ptr=3} → res_valid 2 edges later with res_data=-2, res_err=0, res_ptr=3. Reading ptr 3 afterwards returns opcode=3, a=5, b=-7, result=-2, rd_hit=1.
- Load {DIV, a=-7, b=2} then {MOD, a=-7, b=2} then {DIV, a=9, b=0} back-to-back → results -3, -1, 0(err=1); instr_count=3; one result per cycle.
- Hold res_ready=0 and issue 3 loads → load_ready falls after 2 accepts, and the 3rd is held with no writes beyond the first. Raise res_ready → all 3 results arrive in order with no loss or duplication.
- rd_en on ptr 5 in the same cycle its first write lands → rd_data=0, rd_hit=0; a read on the next cycle returns the new word with rd_hit=1.
- Assert reset while S1 and S2 are both full → all outputs 0 immediately. After release no stale result appears, and instr_count reflects only writes completed before reset is cleared (0).

Source files
------------

// File: rtl/instr_register_pipe.sv
// instr_register_pipe: two-stage instruction pipeline (capture, registered ALU) feeding a register file and a valid/ready result stream, plus a registered read port.
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   load_en, load_ready           instruction handshake (opcode, operand_a, operand_b, write_pointer)
//   res_valid, res_ready          result stream handshake (res_data, res_err, res_ptr)
//   rd_en, read_pointer           read request; answered next cycle on rd_valid, rd_data, rd_hit
//   instr_count                   register-file writes since reset, saturating
module instr_register_pipe #(
   parameter  int OP_WIDTH = 32,
   parameter  int DEPTH    = 32,
   localparam int AW       = $clog2(DEPTH),
   localparam int IW_WIDTH = 4*OP_WIDTH+4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         load_en,
   output logic                         load_ready,
   input  logic [2:0]                   opcode,
   input  logic signed [OP_WIDTH-1:0]   operand_a,
   input  logic signed [OP_WIDTH-1:0]   operand_b,
   input  logic [AW-1:0]                write_pointer,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic signed [2*OP_WIDTH-1:0] res_data,
   output logic                         res_err,
   output logic [AW-1:0]                res_ptr,
   input  logic                         rd_en,
   input  logic [AW-1:0]                read_pointer,
   output logic                         rd_valid,
   output logic [IW_WIDTH-1:0]          rd_data,
   output logic                         rd_hit,
   output logic [15:0]                  instr_count
);
   localparam int RW = 2*OP_WIDTH;
   typedef enum logic [2:0] {
      OP_ZERO  = 3'd0,
      OP_PASSA = 3'd1,
      OP_PASSB = 3'd2,
      OP_ADD   = 3'd3,
      OP_SUB   = 3'd4,
      OP_MULT  = 3'd5,
      OP_DIV   = 3'd6,
      OP_MOD   = 3'd7
   } op_e;
   logic                s1_valid_q, s1_valid_d;
   logic [2:0]          s1_op_q;
   logic [OP_WIDTH-1:0] s1_a_q, s1_b_q;
   logic [AW-1:0]       s1_ptr_q;
   logic                s2_valid_q, s2_valid_d;
   logic signed [RW-1:0] s2_data_q;
   logic                s2_err_q;
   logic [AW-1:0]       s2_ptr_q;
   logic [IW_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]    hit_q;
   logic                rd_valid_q, rd_hit_q;
   logic [IW_WIDTH-1:0] rd_data_q;
   logic [15:0]         cnt_q, cnt_d;
   logic                s1_adv, s2_adv, xfer;
   logic signed [RW-1:0] a_x, b_x, b_div, quot, rem, alu_res;
   logic                b_zero, alu_err;
   // Handshake: a stage may advance when it is empty or the stage after it moves.
   always_comb begin
      s2_adv     = !s2_valid_q || res_ready;
      s1_adv     = !s1_valid_q || s2_adv;
      xfer       = s1_valid_q && s2_adv;
      s1_valid_d = s1_adv ? load_en : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      cnt_d      = (xfer && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   end
   // Held low while reset is asserted so every output reads 0 during reset.
   assign load_ready = s1_adv && !reset;
   always_comb begin
      a_x    = {{OP_WIDTH{s1_a_q[OP_WIDTH-1]}}, s1_a_q};
      b_x    = {{OP_WIDTH{s1_b_q[OP_WIDTH-1]}}, s1_b_q};
      b_zero = (s1_b_q == '0);
      // The divider never sees zero; its output is discarded in that case.
      b_div  = b_zero ? RW'(1) : b_x;
      quot   = a_x / b_div;
      rem    = a_x % b_div;
      alu_res = '0;
      alu_err = 1'b0;
      case (op_e'(s1_op_q))
         OP_PASSA: alu_res = a_x;
         OP_PASSB: alu_res = b_x;
         OP_ADD:   alu_res = a_x + b_x;
         OP_SUB:   alu_res = a_x - b_x;
         OP_MULT:  alu_res = a_x * b_x;
         OP_DIV: begin
            alu_res = b_zero ? '0 : quot;
            alu_err = b_zero;
         end
         OP_MOD: begin
            alu_res = b_zero ? '0 : rem;
            alu_err = b_zero;
         end
         default:  alu_res = '0;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_ptr_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_err_q   <= 1'b0;
         s2_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         cnt_q      <= cnt_d;
         if (load_en && s1_adv) begin
            s1_op_q  <= opcode;
            s1_a_q   <= operand_a;
            s1_b_q   <= operand_b;
            s1_ptr_q <= write_pointer;
         end
         if (xfer) begin
            s2_data_q <= alu_res;
            s2_err_q  <= alu_err;
            s2_ptr_q  <= s1_ptr_q;
         end
      end
   end
   // The register file is written on the same edge the result enters S2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         hit_q <= '0;
      end else if (xfer) begin
         mem_q[s1_ptr_q] <= {alu_err, s1_op_q, s1_a_q, s1_b_q, alu_res};
         hit_q[s1_ptr_q] <= 1'b1;
      end
   end
   // Reads sample the pre-edge array contents, so a same-edge write is not bypassed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_hit_q   <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data_q <= mem_q[read_pointer];
            rd_hit_q  <= hit_q[read_pointer];
         end
      end
   end
   assign res_valid   = s2_valid_q;
   assign res_data    = s2_data_q;
   assign res_err     = s2_err_q;
   assign res_ptr     = s2_ptr_q;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_data_q;
   assign rd_hit      = rd_hit_q;
   assign instr_count = cnt_q;
endmodule
